axis_fifo_pkt: RTL and testbench

//   Parametrised AXI4-Stream buffer with a DEPTH-entry first-word-fall-through FIFO.

---
 rtl/axis_fifo_pkt.sv | 114 +++++++++++
 tb/tb_axis_fifo_pkt.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: AXI4-Stream first-word-fall-through FIFO with tlast carried
// alongside each word, an occupancy output and optional store-and-forward
// packet mode. Handshake flags depend only on registered state, plus the
// reset input, so the consumer's m_tready never reaches s_tready in one cycle.
module axis_fifo_pkt #(
  parameter int N        = 8,
  parameter int DEPTH    = 16,
  parameter int PKT_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N-1:0]               s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  output logic [N-1:0]               m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry holds {tlast, data} so packet boundaries travel with the data.
  logic [N:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pktCnt_q, pktCnt_d;
  logic          readyEn_q;

  logic full;
  logic empty;
  logic releaseOk;
  logic push;
  logic pop;
  logic pktIn;
  logic pktOut;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Decide whether the stored words may be presented: always in cut-through
  // mode; in packet mode only once a whole packet is stored, or when the FIFO
  // is full, so that a packet longer than the FIFO cannot deadlock it.
  always_comb begin
    releaseOk = 1'b1;
    if (PKT_MODE != 0) begin
      releaseOk = (pktCnt_q != '0) || full;
    end
  end

  assign s_tready = reset_n & readyEn_q & ~full;
  assign m_tvalid = ~empty & releaseOk;
  assign m_tdata  = mem_q[rdPtr_q][N-1:0];
  assign m_tlast  = mem_q[rdPtr_q][N];
  assign count    = count_q;

  assign push   = s_tvalid & s_tready;
  assign pop    = m_tvalid & m_tready;
  assign pktIn  = push & s_tlast;
  assign pktOut = pop & m_tlast;

  // Next-state for pointers, occupancy and the count of complete stored packets.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    pktCnt_d = pktCnt_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (pktIn && !pktOut) begin
      pktCnt_d = pktCnt_q + CW'(1);
    end else if (pktOut && !pktIn) begin
      pktCnt_d = pktCnt_q - CW'(1);
    end
  end

  // Control state; readyEn_q holds s_tready low until one edge after reset release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      pktCnt_q  <= '0;
      readyEn_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      pktCnt_q  <= pktCnt_d;
      readyEn_q <= 1'b1;
    end
  end

  // Storage array; its contents are meaningless until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {s_tlast, s_tdata};
    end
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// tb_axis_fifo_pkt: drives a cut-through instance (unit 0) and a
// store-and-forward instance (unit 1) of axis_fifo_pkt, sharing clock and reset.
module tb_axis_fifo_pkt;

  logic clk = 1'b0;
  logic reset_n;

  logic [7:0] sData  [2];
  logic       sValid [2];
  logic       sLast  [2];
  logic       mReady [2];
  logic       sReady [2];
  logic [7:0] mData  [2];
  logic       mValid [2];
  logic       mLast  [2];
  logic [4:0] cnt    [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state per unit, advanced at every falling edge.
  int         mCount   [2];
  int         mPkt     [2];
  bit         mReadyEn [2];
  logic [8:0] sbQ0 [$];
  logic [8:0] sbQ1 [$];
  bit         monOn = 1'b0;

  typedef struct {
    bit         sv;
    logic [7:0] sd;
    bit         sl;
    bit         mr;
    bit         ev;
    logic [7:0] ed;
    bit         el;
    int         ec;
    bit         er;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  axis_fifo_pkt #(.N(8), .DEPTH(16), .PKT_MODE(0)) dutCut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(sData[0]), .s_tvalid(sValid[0]), .s_tready(sReady[0]), .s_tlast(sLast[0]),
    .m_tdata(mData[0]), .m_tvalid(mValid[0]), .m_tready(mReady[0]), .m_tlast(mLast[0]),
    .count(cnt[0])
  );

  axis_fifo_pkt #(.N(8), .DEPTH(16), .PKT_MODE(1)) dutPkt (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(sData[1]), .s_tvalid(sValid[1]), .s_tready(sReady[1]), .s_tlast(sLast[1]),
    .m_tdata(mData[1]), .m_tvalid(mValid[1]), .m_tready(mReady[1]), .m_tlast(mLast[1]),
    .count(cnt[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int u, input bit v, input logic [7:0] d, input bit l, input bit r);
    sValid[u] = v;
    sData[u]  = d;
    sLast[u]  = l;
    mReady[u] = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input int u, input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cnt[u] == 5'd0) break;
    end
    checkOutput(name, cnt[u], 0);
    nextCycle();
  endtask

  // Scoreboard: predict flags and count, queue pushed words, compare popped words.
  always @(negedge clk) begin
    bit         expReady;
    bit         expValid;
    bit         doPush;
    bit         doPop;
    logic [8:0] front;
    if (monOn) begin
      for (int u = 0; u < 2; u++) begin
        expReady = reset_n && mReadyEn[u] && (mCount[u] != 16);
        expValid = (mCount[u] != 0) && ((u == 0) || (mPkt[u] != 0) || (mCount[u] == 16));
        checkOutput($sformatf("u%0d s_tready", u), sReady[u], expReady);
        checkOutput($sformatf("u%0d m_tvalid", u), mValid[u], expValid);
        checkOutput($sformatf("u%0d count", u), cnt[u], mCount[u]);
        if (!reset_n) begin
          mCount[u]   = 0;
          mPkt[u]     = 0;
          mReadyEn[u] = 1'b0;
          if (u == 0) sbQ0.delete(); else sbQ1.delete();
        end else begin
          doPush = sValid[u] && expReady;
          doPop  = expValid && mReady[u];
          if (doPop) begin
            if (((u == 0) ? sbQ0.size() : sbQ1.size()) == 0) begin
              checkOutput($sformatf("u%0d scoreboard nonempty", u), 0, 1);
            end else begin
              front = (u == 0) ? sbQ0.pop_front() : sbQ1.pop_front();
              checkOutput($sformatf("u%0d m_tdata", u), mData[u], front[7:0]);
              checkOutput($sformatf("u%0d m_tlast", u), mLast[u], front[8]);
              if (front[8]) mPkt[u]--;
            end
            mCount[u]--;
          end
          if (doPush) begin
            if (u == 0) sbQ0.push_back({sLast[u], sData[u]});
            else        sbQ1.push_back({sLast[u], sData[u]});
            if (sLast[u]) mPkt[u]++;
            mCount[u]++;
          end
          mReadyEn[u] = 1'b1;
        end
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int accepted;

    vecs[0] = '{1, 8'h68, 1, 1, 0, 8'h00, 0, 0, 1};
    vecs[1] = '{0, 8'h00, 0, 1, 1, 8'h68, 1, 1, 1};
    vecs[2] = '{1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 1};
    vecs[3] = '{1, 8'h3C, 1, 0, 1, 8'hA5, 0, 1, 1};
    vecs[4] = '{0, 8'h00, 0, 0, 1, 8'hA5, 0, 2, 1};
    vecs[5] = '{0, 8'h00, 0, 1, 1, 8'hA5, 0, 2, 1};
    vecs[6] = '{1, 8'h11, 0, 1, 1, 8'h3C, 1, 1, 1};
    vecs[7] = '{0, 8'h00, 0, 1, 1, 8'h11, 0, 1, 1};
    vecs[8] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1};

    for (int u = 0; u < 2; u++) begin
      applyStimulus(u, 0, 8'h00, 0, 0);
      mCount[u]   = 0;
      mPkt[u]     = 0;
      mReadyEn[u] = 1'b0;
    end
    reset_n = 1'b0;
    nextCycle();
    monOn = 1'b1;
    nextCycle();
    reset_n = 1'b1;
    nextCycle();

    // Single-beat packet and short mixed sequences on the cut-through unit.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].mr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d m_tvalid", i), mValid[0], vecs[i].ev);
      checkOutput($sformatf("vec%0d count", i), cnt[0], vecs[i].ec);
      checkOutput($sformatf("vec%0d s_tready", i), sReady[0], vecs[i].er);
      if (vecs[i].ev) begin
        checkOutput($sformatf("vec%0d m_tdata", i), mData[0], vecs[i].ed);
        checkOutput($sformatf("vec%0d m_tlast", i), mLast[0], vecs[i].el);
      end
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 0, 0);

    // Fill to full, hold a word on s_* while full, then drain in order.
    for (int b = 0; b < 16; b++) begin
      applyStimulus(0, 1, 8'(b), (b == 15), 0);
      nextCycle();
    end
    applyStimulus(0, 1, 8'h99, 1, 0);
    @(negedge clk);
    checkOutput("t2 full s_tready", sReady[0], 0);
    checkOutput("t2 full count", cnt[0], 16);
    nextCycle();
    applyStimulus(0, 1, 8'h99, 1, 1);
    @(negedge clk);
    checkOutput("t2 still full", sReady[0], 0);
    checkOutput("t2 head", mData[0], 8'h00);
    nextCycle();
    @(negedge clk);
    checkOutput("t2 ready after pop", sReady[0], 1);
    checkOutput("t2 count after pop", cnt[0], 15);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 0, 1);
    waitEmpty(0, "t2 drain", 40);

    // Hold occupancy at 8 with simultaneous push and pop across pointer wrap.
    for (int b = 0; b < 8; b++) begin
      applyStimulus(0, 1, 8'h20 + 8'(b), 0, 0);
      nextCycle();
    end
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 1, 8'h40 + 8'(c), (c % 7 == 0), 1);
      @(negedge clk);
      checkOutput("t3 steady count", cnt[0], 8);
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 0, 1);
    waitEmpty(0, "t3 drain", 40);

    // Store-and-forward: nothing is presented until the tlast beat is stored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 8'h50 + 8'(i), (i == 4), 1);
      @(negedge clk);
      checkOutput("t4 held back", mValid[1], 0);
      nextCycle();
    end
    applyStimulus(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t4 burst valid", mValid[1], 1);
      checkOutput("t4 burst data", mData[1], 8'h50 + 8'(i));
      checkOutput("t4 burst last", mLast[1], (i == 4));
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t4 done valid", mValid[1], 0);
    checkOutput("t4 done count", cnt[1], 0);
    nextCycle();

    // Store-and-forward with a packet longer than the FIFO: full-release drains.
    accepted = 0;
    for (int c = 0; c < 200 && accepted < 20; c++) begin
      applyStimulus(1, 1, 8'h80 + 8'(accepted), 0, 1);
      @(negedge clk);
      if (sReady[1]) accepted++;
      nextCycle();
    end
    checkOutput("t5 beats accepted", accepted, 20);
    applyStimulus(1, 0, 8'h00, 0, 1);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("t5 partial count", cnt[1], 15);
    checkOutput("t5 partial valid", mValid[1], 0);
    nextCycle();
    applyStimulus(1, 1, 8'hEE, 1, 1);
    nextCycle();
    applyStimulus(1, 0, 8'h00, 0, 1);
    waitEmpty(1, "t5 drain", 60);

    // Reset with six words stored discards them and re-arms s_tready late.
    for (int b = 0; b < 6; b++) begin
      applyStimulus(0, 1, 8'hC0 + 8'(b), (b == 5), 0);
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 0, 1);
    @(negedge clk);
    checkOutput("t6 stored", cnt[0], 6);
    nextCycle();
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("t6 ready in reset", sReady[0], 0);
    nextCycle();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t6 count cleared", cnt[0], 0);
    checkOutput("t6 valid cleared", mValid[0], 0);
    checkOutput("t6 ready first edge", sReady[0], 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6 ready rearmed", sReady[0], 1);
    checkOutput("t6 no stale beat", mValid[0], 0);
    nextCycle();

    checkOutput("u0 scoreboard empty", sbQ0.size(), 0);
    checkOutput("u1 scoreboard empty", sbQ1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
